// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses HDR/CMD/DATA frames from the receiver,
// applies writes to a control register and sends ACK/NAK (+ read data) back
// through a busy-handshaked transmitter.
module uart_cmd_ctrl #(
   parameter int unsigned TIMEOUT = 100000,
   parameter logic [7:0]  HDR     = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_recieved,
   input  logic [7:0] rx_output,
   input  logic       tx_busy,
   output logic       tx_start,
   output logic [7:0] tx_input,
   output logic [7:0] reg_out,
   output logic [7:0] drop_cnt,
   output logic [7:0] err_cnt
);

   localparam logic [7:0]  CmdWrite = 8'h01;
   localparam logic [7:0]  CmdRead  = 8'h02;
   localparam logic [7:0]  RespAck  = 8'h06;
   localparam logic [7:0]  RespNak  = 8'h15;
   // Timer value at which the next idle cycle makes it reach TIMEOUT.
   localparam logic [31:0] TimerMax = 32'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StGotHdr,
      StGotCmd,
      StSend,
      StWaitHi,
      StWaitLo
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] timer_q, timer_d;
   logic [7:0]  cmd_q, cmd_d;
   logic [7:0]  resp1_q, resp1_d;
   logic        second_q, second_d;
   logic [7:0]  tx_input_q, tx_input_d;
   logic [7:0]  reg_q, reg_d;
   logic [7:0]  drop_q, drop_d;
   logic [7:0]  err_q, err_d;
   logic        responding;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign responding = (state_q == StSend) || (state_q == StWaitHi) || (state_q == StWaitLo);

   // Next-state, response selection, counters and the tx_start strobe.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      cmd_d      = cmd_q;
      resp1_d    = resp1_q;
      second_d   = second_q;
      tx_input_d = tx_input_q;
      reg_d      = reg_q;
      drop_d     = drop_q;
      err_d      = err_q;
      tx_start   = 1'b0;

      case (state_q)
         StIdle: begin
            timer_d = '0;
            if (rx_recieved && (rx_output == HDR)) begin
               state_d = StGotHdr;
            end
         end
         StGotHdr: begin
            // A byte in the timeout cycle wins over the timeout.
            if (rx_recieved) begin
               cmd_d   = rx_output;
               timer_d = '0;
               state_d = StGotCmd;
            end else if (timer_q == TimerMax) begin
               timer_d = '0;
               err_d   = sat_inc(err_q);
               state_d = StIdle;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         StGotCmd: begin
            if (rx_recieved) begin
               timer_d  = '0;
               second_d = 1'b0;
               state_d  = StSend;
               case (cmd_q)
                  CmdWrite: begin
                     reg_d      = rx_output;
                     tx_input_d = RespAck;
                  end
                  CmdRead: begin
                     tx_input_d = RespAck;
                     resp1_d    = reg_q;
                     second_d   = 1'b1;
                  end
                  default: begin
                     tx_input_d = RespNak;
                     err_d      = sat_inc(err_q);
                  end
               endcase
            end else if (timer_q == TimerMax) begin
               timer_d = '0;
               err_d   = sat_inc(err_q);
               state_d = StIdle;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         StSend: begin
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_d  = StWaitHi;
            end
         end
         StWaitHi: begin
            if (tx_busy) begin
               state_d = StWaitLo;
            end
         end
         StWaitLo: begin
            if (!tx_busy) begin
               if (second_q) begin
                  tx_input_d = resp1_q;
                  second_d   = 1'b0;
                  state_d    = StSend;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (rx_recieved && responding) begin
         drop_d = sat_inc(drop_q);
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         cmd_q      <= '0;
         resp1_q    <= '0;
         second_q   <= 1'b0;
         tx_input_q <= '0;
         reg_q      <= '0;
         drop_q     <= '0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         cmd_q      <= cmd_d;
         resp1_q    <= resp1_d;
         second_q   <= second_d;
         tx_input_q <= tx_input_d;
         reg_q      <= reg_d;
         drop_q     <= drop_d;
         err_q      <= err_d;
      end
   end

   assign tx_input = tx_input_q;
   assign reg_out  = reg_q;
   assign drop_cnt = drop_q;
   assign err_cnt  = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Bench for uart_cmd_ctrl: transmitter busy model plus a scoreboard of
// expected transmitted bytes, with register/counter checks between frames.
module tb_uart_cmd_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_recieved = 1'b0;
   logic [7:0] rx_output = 8'h00;
   logic       tx_busy = 1'b0;
   logic       tx_start;
   logic [7:0] tx_input;
   logic [7:0] reg_out;
   logic [7:0] drop_cnt;
   logic [7:0] err_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_tx[$];
   int         busy_len = 10;
   int         busy_cnt = 0;
   logic       pend = 1'b0;
   logic       prev_start = 1'b0;
   logic [7:0] held = 8'h00;
   logic       held_valid = 1'b0;
   int         cyc = 0;
   int         last_rx_cyc = 0;
   logic [7:0] exp_err = 8'h00;

   uart_cmd_ctrl #(
      .TIMEOUT(50),
      .HDR    (8'hA5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_recieved(rx_recieved),
      .rx_output  (rx_output),
      .tx_busy    (tx_busy),
      .tx_start   (tx_start),
      .tx_input   (tx_input),
      .reg_out    (reg_out),
      .drop_cnt   (drop_cnt),
      .err_cnt    (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Transmitter model and tx monitor, evaluated 2 time units after each rising edge.
   always begin
      logic       st;
      logic [7:0] ti;
      logic       bz;
      @(posedge clk);
      #2;
      cyc++;
      st = tx_start;
      ti = tx_input;
      bz = tx_busy;
      if (rst) begin
         held_valid = 1'b0;
         prev_start = 1'b0;
      end
      if (st) begin
         check_eq("start_while_busy", 32'(bz), 32'd0);
         check_eq("start_back_to_back", 32'(prev_start), 32'd0);
         check_eq("start_latency", 32'(cyc > last_rx_cyc), 32'd1);
         if (exp_tx.size() == 0) begin
            check_eq("tx_unexpected", 32'(exp_tx.size()), 32'd1);
         end else begin
            check_eq("tx_byte", 32'(ti), 32'(exp_tx.pop_front()));
         end
         held       = ti;
         held_valid = 1'b1;
      end
      prev_start = st;
      if (pend) begin
         tx_busy  = 1'b1;
         busy_cnt = busy_len;
         pend     = 1'b0;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            if (held_valid) check_eq("tx_input_hold", 32'(tx_input), 32'(held));
            held_valid = 1'b0;
            tx_busy    = 1'b0;
         end
      end
      if (st) pend = 1'b1;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_output   = b;
      rx_recieved = 1'b1;
      last_rx_cyc = cyc;
      @(negedge clk);
      rx_recieved = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] d);
      send_byte(8'hA5);
      send_byte(c);
      send_byte(d);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (n < budget && !(exp_tx.size() == 0 && !tx_busy && !pend && busy_cnt == 0)) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) check_eq("drain_timeout", 32'(exp_tx.size()), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_tx_start"}, 32'(tx_start), 32'd0);
      check_eq({tag, "_tx_input"}, 32'(tx_input), 32'd0);
      check_eq({tag, "_reg_out"}, 32'(reg_out), 32'd0);
      check_eq({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
      check_eq({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Write 3C.
      exp_tx.push_back(8'h06);
      send_frame(8'h01, 8'h3C);
      wait_idle(200);
      check_eq("write_reg", 32'(reg_out), 32'h3C);
      check_eq("write_err", 32'(err_cnt), 32'(exp_err));

      // Read: ACK then current register value.
      exp_tx.push_back(8'h06);
      exp_tx.push_back(8'h3C);
      send_frame(8'h02, 8'h00);
      wait_idle(200);
      check_eq("read_reg", 32'(reg_out), 32'h3C);

      // Unknown command.
      exp_tx.push_back(8'h15);
      send_frame(8'h7F, 8'h00);
      wait_idle(200);
      exp_err++;
      check_eq("badcmd_err", 32'(err_cnt), 32'(exp_err));
      check_eq("badcmd_reg", 32'(reg_out), 32'h3C);

      // Timeout after header; trailing bytes are ignored in idle.
      send_byte(8'hA5);
      repeat (60) @(negedge clk);
      send_byte(8'h01);
      send_byte(8'h3C);
      repeat (30) @(negedge clk);
      exp_err++;
      check_eq("timeout_err", 32'(err_cnt), 32'(exp_err));
      check_eq("timeout_reg", 32'(reg_out), 32'h3C);
      exp_tx.push_back(8'h06);
      send_frame(8'h01, 8'h11);
      wait_idle(200);
      check_eq("after_timeout_reg", 32'(reg_out), 32'h11);

      // Gaps below the timeout: the timer restarts on every byte.
      exp_tx.push_back(8'h06);
      send_byte(8'hA5);
      repeat (40) @(negedge clk);
      send_byte(8'h01);
      repeat (40) @(negedge clk);
      send_byte(8'h22);
      wait_idle(200);
      check_eq("gap_reg", 32'(reg_out), 32'h22);
      check_eq("gap_err", 32'(err_cnt), 32'(exp_err));

      // Overrun during read response.
      exp_tx.push_back(8'h06);
      exp_tx.push_back(8'h22);
      send_frame(8'h02, 8'h00);
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h99);
      wait_idle(200);
      check_eq("overrun_drop", 32'(drop_cnt), 32'd3);
      check_eq("overrun_reg", 32'(reg_out), 32'h22);
      check_eq("overrun_err", 32'(err_cnt), 32'(exp_err));

      // Drop counter saturation under a long busy period.
      busy_len = 700;
      exp_tx.push_back(8'h06);
      send_frame(8'h01, 8'h22);
      for (int i = 0; i < 300; i++) send_byte(8'($urandom_range(0, 255)));
      busy_len = 10;
      wait_idle(1000);
      check_eq("drop_saturate", 32'(drop_cnt), 32'hFF);
      check_eq("drop_saturate_reg", 32'(reg_out), 32'h22);

      // Reset in the middle of a read response.
      exp_tx.push_back(8'h06);
      exp_tx.push_back(8'h22);
      send_frame(8'h02, 8'h00);
      n = 0;
      while (n < 100 && !tx_busy) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check_eq("busy_wait_timeout", 32'(tx_busy), 32'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check_reset_values("midrst");
      exp_tx.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      // A partial frame without header must not be resumed.
      send_byte(8'h01);
      send_byte(8'h77);
      repeat (10) @(negedge clk);
      check_eq("no_resume_reg", 32'(reg_out), 32'h00);
      exp_tx.push_back(8'h06);
      send_frame(8'h01, 8'h5A);
      wait_idle(200);
      check_eq("post_rst_reg", 32'(reg_out), 32'h5A);
      check_eq("post_rst_drop", 32'(drop_cnt), 32'd0);
      check_eq("post_rst_err", 32'(err_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 100000: max clk cycles allowed between bytes of one command before the command is abandoned.
REQ-002 Parameter HDR, default 8'hA5: command header byte.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rx_recieved  input  1  one-cycle pulse: a byte is valid on rx_output.
REQ-006 rx_output  input  8  received byte, sampled only when rx_recieved=1.
REQ-007 tx_busy  input  1  transmitter busy; 1 while a byte is shifting out.
REQ-008 tx_start  output  1  one-cycle pulse requesting transmission of tx_input.
REQ-009 tx_input  output  8  byte to transmit; stable from the tx_start cycle until tx_busy falls.
REQ-010 reg_out  output  8  control register written by host (drives LEDS).
REQ-011 drop_cnt  output  8  count of received bytes discarded while responding.
REQ-012 err_cnt  output  8  count of NAKed or timed-out commands.

Function
REQ-013 Frame: 3 bytes in order HDR, CMD, DATA.
REQ-014 CMD 8'h01 = write: reg_out <= DATA, respond ACK 8'h06.
REQ-015 CMD 8'h02 = read: respond ACK 8'h06, then the current reg_out value (DATA ignored).
REQ-016 Any other CMD: respond NAK 8'h15 after DATA arrives; err_cnt +1.
REQ-017 States: IDLE, GOT_HDR, GOT_CMD, SEND, WAIT_HI, WAIT_LO.
REQ-018 IDLE: byte==HDR -> GOT_HDR; any other byte ignored, no count.
REQ-019 GOT_HDR: next byte latched as CMD -> GOT_CMD.
REQ-020 GOT_CMD: next byte latched as DATA; write applied in that same cycle's update (reg_out valid the following cycle); -> SEND.
REQ-021 SEND: when tx_busy=0, pulse tx_start for exactly one cycle with tx_input = current response byte -> WAIT_HI.
REQ-022 WAIT_HI: wait for tx_busy=1 -> WAIT_LO; WAIT_LO: wait for tx_busy=0, then -> SEND if a second response byte remains, else IDLE.
REQ-023 tx_start never asserted in consecutive cycles and never while tx_busy=1.
REQ-024 Latency: tx_start no earlier than 1 cycle after the DATA rx_recieved pulse.
REQ-025 Inter-byte timer: cleared on every accepted byte, counts in GOT_HDR and GOT_CMD; reaching TIMEOUT -> IDLE, err_cnt +1, no response.
REQ-026 Bytes arriving in SEND/WAIT_HI/WAIT_LO are discarded; drop_cnt +1 each.
REQ-027 Timeout and rx_recieved in the same cycle: the byte is accepted, timeout ignored.
REQ-028 drop_cnt and err_cnt saturate at 8'hFF (no wrap).
REQ-029 Read response second byte is reg_out sampled when DATA was accepted.

Reset
REQ-030 rst=1 forces IDLE immediately, regardless of state or transmission in progress.
REQ-031 Reset values: tx_start=0, tx_input=8'h00, reg_out=8'h00, drop_cnt=0, err_cnt=0, timer=0.
REQ-032 After rst falls, the first accepted byte must be a fresh HDR; partial frames are never resumed.

Verification
REQ-033 Write: A5,01,3C with tx_busy modelled (1 cycle after tx_start, 10 cycles busy) -> reg_out=8'h3C, single tx byte 06.
REQ-034 Read: after REQ-033, send A5,02,00 -> tx bytes 06 then 3C, second tx_start only after tx_busy fell.
REQ-035 Bad CMD: A5,7F,00 -> tx byte 15, err_cnt=1, reg_out unchanged.
REQ-036 Timeout (TIMEOUT=50): A5, then idle 60 cycles, then 01,3C -> no tx, err_cnt=1, reg_out unchanged; following A5,01,11 -> reg_out=8'h11.
REQ-037 Overrun: during read response inject 3 bytes -> drop_cnt=3, response bytes unaffected; 300 overruns -> drop_cnt=8'hFF.
REQ-038 Reset mid-response: assert rst in WAIT_LO -> all outputs at reset values, no further tx_start until a new complete frame.
